// File: rtl/picorv_issue.sv
// picorv_issue: single-issue sequencer sitting in front of picorv_exec.
// Takes one instruction from fetch, strobes it on the decode bus, and then
// presents it with register-file operands on the pcpi bus until an execution
// unit retires it. On retire it writes rd and forwards branch redirects back
// to fetch. A watchdog traps if no unit claims the instruction.
module picorv_issue #(
  parameter int XLEN    = 32,
  parameter int ILEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [ILEN-1:0] fetch_insn,
  input  logic [15:0]     fetch_prefix,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            decode_valid,
  output logic [ILEN-1:0] decode_insn,
  output logic [15:0]     decode_prefix,
  output logic            pcpi_valid,
  output logic [ILEN-1:0] pcpi_insn,
  output logic [15:0]     pcpi_prefix,
  output logic [XLEN-1:0] pcpi_pc,
  output logic            pcpi_rs1_valid,
  output logic [XLEN-1:0] pcpi_rs1_data,
  output logic            pcpi_rs2_valid,
  output logic [XLEN-1:0] pcpi_rs2_data,
  output logic            pcpi_rs3_valid,
  output logic [XLEN-1:0] pcpi_rs3_data,
  input  logic            pcpi_ready,
  output logic            pcpi_wb_valid,
  input  logic            pcpi_wb_write,
  input  logic [XLEN-1:0] pcpi_wb_data,
  input  logic            pcpi_br_enable,
  input  logic [XLEN-1:0] pcpi_br_nextpc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trap
);

  // Counter must be able to hold TIMEOUT itself (value reached on expiry).
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, TRAP} state_t;

  state_t          state;
  state_t          state_next;
  logic [ILEN-1:0] insn;
  logic [15:0]     prefix;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] regs [32];

  logic            in_exec;
  logic            transfer;
  logic            retire;
  logic            expire;
  logic [4:0]      rd;

  // x0 is hardwired to zero; the storage entry behind it is never written.
  function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx);
    read_reg = (idx == 5'd0) ? '0 : regs[idx];
  endfunction

  assign in_exec  = (state == EXEC);
  assign transfer = fetch_valid && fetch_ready;
  assign retire   = in_exec && pcpi_ready;
  // Retire in the last allowed cycle takes priority over the timeout.
  assign expire   = in_exec && !pcpi_ready && (count == CW'(TIMEOUT - 1));
  assign rd       = insn[11:7];

  // fetch_ready is qualified by resetn so it reads 0 while reset is held.
  assign fetch_ready    = resetn && (state == IDLE) && !redirect_valid && !trap;
  assign trap           = (state == TRAP);
  assign decode_valid   = (state == DECODE);
  assign decode_insn    = insn;
  assign decode_prefix  = prefix;
  assign pcpi_valid     = in_exec;
  assign pcpi_insn      = insn;
  assign pcpi_prefix    = prefix;
  assign pcpi_pc        = pc;
  assign pcpi_wb_valid  = in_exec;
  assign pcpi_rs1_valid = in_exec;
  assign pcpi_rs2_valid = in_exec;
  assign pcpi_rs3_valid = in_exec;
  // Operands are gated so unreset storage never shows outside EXEC.
  assign pcpi_rs1_data  = in_exec ? read_reg(insn[19:15]) : '0;
  assign pcpi_rs2_data  = in_exec ? read_reg(insn[24:20]) : '0;
  assign pcpi_rs3_data  = in_exec ? read_reg(insn[31:27]) : '0;

  // Next-state logic for the issue sequence; TRAP is left only by reset.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (transfer) state_next = DECODE;
      DECODE:  state_next = EXEC;
      EXEC: begin
        if (retire)      state_next = IDLE;
        else if (expire) state_next = TRAP;
      end
      TRAP:    state_next = TRAP;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Capture the instruction on the fetch handshake; held until the next one.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      insn   <= '0;
      prefix <= '0;
      pc     <= '0;
    end else if (transfer) begin
      insn   <= fetch_insn;
      prefix <= fetch_prefix;
      pc     <= fetch_pc;
    end
  end

  // Watchdog: cleared while entering EXEC, counts EXEC cycles without ready.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                    count <= '0;
    else if (state == DECODE)       count <= '0;
    else if (in_exec && !pcpi_ready) count <= count + CW'(1);
  end

  // Redirect pulse lasts exactly one cycle after a taken-branch retire.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= retire && pcpi_br_enable;
      if (retire && pcpi_br_enable) redirect_pc <= pcpi_br_nextpc;
    end
  end

  // Register file write on retire; contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (retire && pcpi_wb_write && (rd != 5'd0)) regs[rd] <= pcpi_wb_data;
  end

endmodule
